// File: rtl/rsa_modexp_ctrl_pkg.sv
// Shared definitions for the RSA modular-exponentiation controller.
//   rsa_width     : default operand/modulus width
//   rsa_exp_bits  : default exponent width
//   state_t       : controller FSM encoding
//   mm_op_count() : Montgomery products needed for one exponentiation
package rsa_modexp_ctrl_pkg;

   localparam int unsigned RsaWidth   = 512;
   localparam int unsigned RsaExpBits = 512;

   // Each product uses an issue state (one cycle, mm_start high) followed by a wait state.
   typedef enum logic [3:0] {
      StIdle,
      StConv,
      StConvW,
      StSqr,
      StSqrW,
      StMul,
      StMulW,
      StStep,
      StPost,
      StPostW,
      StDone
   } state_t;

   // One conversion, one square per exponent bit, one multiply per set bit, one
   // conversion back out of Montgomery form.
   function automatic int unsigned mm_op_count(input int unsigned exp_bits,
                                               input int unsigned set_bits);
      return exp_bits + set_bits + 2;
   endfunction

endpackage

// File: rtl/rsa_modexp_ctrl.sv
// Left-to-right square-and-multiply controller computing result = x^e mod m. It owns a
// single Montgomery multiplier (MM(a,b) = a*b*R^-1 mod m, R = 2^N) and drives it over
// a start/done handshake, one product at a time.
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   start              pulse; samples in_x/in_e/in_m/in_r/in_r2 when idle
//   in_x, in_e, in_m   base (< m), exponent (scanned MSB first), odd modulus
//   in_r, in_r2        R mod m and R^2 mod m
//   result             x^e mod m, valid with done and held until overwritten
//   done, busy         completion pulse; high from accepted start through done
//   mm_start           one-cycle request to the multiplier
//   mm_a, mm_b, mm_m   multiplier operands, stable from mm_start through mm_done
//   mm_result, mm_done multiplier response, sampled only in a wait state
module rsa_modexp_ctrl
   import rsa_modexp_ctrl_pkg::*;
#(
   parameter int unsigned N        = RsaWidth,
   parameter int unsigned EXP_BITS = RsaExpBits
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                start,
   input  logic [N-1:0]        in_x,
   input  logic [EXP_BITS-1:0] in_e,
   input  logic [N-1:0]        in_m,
   input  logic [N-1:0]        in_r,
   input  logic [N-1:0]        in_r2,
   output logic [N-1:0]        result,
   output logic                done,
   output logic                busy,
   output logic                mm_start,
   output logic [N-1:0]        mm_a,
   output logic [N-1:0]        mm_b,
   output logic [N-1:0]        mm_m,
   input  logic [N-1:0]        mm_result,
   input  logic                mm_done
);

   localparam int unsigned     IdxW   = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;
   localparam logic [IdxW-1:0] IdxMax = IdxW'(EXP_BITS - 1);
   localparam logic [N-1:0]    One    = {{(N-1){1'b0}}, 1'b1};

   state_t              state_q;
   logic [N-1:0]        xt_q;   // base in Montgomery form
   logic [N-1:0]        acc_q;  // running product in Montgomery form
   logic [EXP_BITS-1:0] e_q;
   logic [IdxW-1:0]     idx_q;

   // Operands are only written on the transition into an issue state, so they stay
   // put for the whole issue/wait pair and the handshake needs no extra holding logic.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= StIdle;
         xt_q     <= '0;
         acc_q    <= '0;
         e_q      <= '0;
         idx_q    <= '0;
         result   <= '0;
         done     <= 1'b0;
         busy     <= 1'b0;
         mm_start <= 1'b0;
         mm_a     <= '0;
         mm_b     <= '0;
         mm_m     <= '0;
      end else begin
         mm_start <= 1'b0;
         done     <= 1'b0;
         case (state_q)
            StIdle: begin
               // mm_done is not looked at here, so a stray pulse alongside start is dropped.
               if (start) begin
                  e_q      <= in_e;
                  acc_q    <= in_r;  // Montgomery form of 1
                  mm_m     <= in_m;
                  mm_a     <= in_x;
                  mm_b     <= in_r2; // MM(x, R^2) = x*R mod m
                  mm_start <= 1'b1;
                  busy     <= 1'b1;
                  state_q  <= StConv;
               end
            end
            StConv: state_q <= StConvW;
            StConvW: begin
               if (mm_done) begin
                  xt_q     <= mm_result;
                  idx_q    <= IdxMax;
                  mm_a     <= acc_q;
                  mm_b     <= acc_q;
                  mm_start <= 1'b1;
                  state_q  <= StSqr;
               end
            end
            StSqr: state_q <= StSqrW;
            StSqrW: begin
               if (mm_done) begin
                  acc_q <= mm_result;
                  if (e_q[idx_q]) begin
                     mm_a     <= mm_result;
                     mm_b     <= xt_q;
                     mm_start <= 1'b1;
                     state_q  <= StMul;
                  end else begin
                     state_q <= StStep;
                  end
               end
            end
            StMul: state_q <= StMulW;
            StMulW: begin
               if (mm_done) begin
                  acc_q   <= mm_result;
                  state_q <= StStep;
               end
            end
            StStep: begin
               mm_a     <= acc_q;
               mm_start <= 1'b1;
               if (idx_q == '0) begin
                  mm_b    <= One;  // MM(acc, 1) leaves Montgomery form
                  state_q <= StPost;
               end else begin
                  idx_q   <= idx_q - 1'b1;
                  mm_b    <= acc_q;
                  state_q <= StSqr;
               end
            end
            StPost: state_q <= StPostW;
            StPostW: begin
               if (mm_done) begin
                  result  <= mm_result;
                  done    <= 1'b1;
                  state_q <= StDone;
               end
            end
            StDone: begin
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Directed bench for rsa_modexp_ctrl at N=16, EXP_BITS=8 with a behavioural Montgomery
// multiplier of random latency 1..40 cycles. Expected results are hand-computed.
module tb_rsa_modexp_ctrl;

   localparam int unsigned W  = 16;
   localparam int unsigned EB = 8;

   logic          clk    = 1'b0;
   logic          resetn = 1'b0;
   logic          start  = 1'b0;
   logic [W-1:0]  in_x   = '0;
   logic [EB-1:0] in_e   = '0;
   logic [W-1:0]  in_m   = '0;
   logic [W-1:0]  in_r   = '0;
   logic [W-1:0]  in_r2  = '0;
   logic [W-1:0]  result;
   logic          done;
   logic          busy;
   logic          mm_start;
   logic [W-1:0]  mm_a;
   logic [W-1:0]  mm_b;
   logic [W-1:0]  mm_m;
   logic [W-1:0]  mm_result;
   logic          mm_done;

   int vectors     = 0;
   int miscompares = 0;

   rsa_modexp_ctrl #(.N(W), .EXP_BITS(EB)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .start     (start),
      .in_x      (in_x),
      .in_e      (in_e),
      .in_m      (in_m),
      .in_r      (in_r),
      .in_r2     (in_r2),
      .result    (result),
      .done      (done),
      .busy      (busy),
      .mm_start  (mm_start),
      .mm_a      (mm_a),
      .mm_b      (mm_b),
      .mm_m      (mm_m),
      .mm_result (mm_result),
      .mm_done   (mm_done)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural multiplier + handshake monitor ----------------
   function automatic logic [W-1:0] mm_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] m);
      logic [47:0] t;
      t = {32'h0, a} * {32'h0, b};
      for (int k = 0; k < int'(W); k++) begin
         if (t[0]) t = t + {32'h0, m};
         t = t >> 1;
      end
      if (t >= {32'h0, m}) t = t - {32'h0, m};
      return t[W-1:0];
   endfunction

   logic         pend      = 1'b0;
   int           lat_cnt   = 0;
   logic [W-1:0] a0, b0, m0, res_pend;
   logic         mm_done_m = 1'b0;
   logic [W-1:0] mm_res_m  = '0;
   logic         spur      = 1'b0;
   logic         spur_en   = 1'b0;
   int           start_cnt = 0;
   int           done_cnt  = 0;
   int           hold_err  = 0;
   int           overlap_err = 0;

   // Spurious mm_done carries a garbage value so any wrongful capture is visible.
   assign mm_done   = mm_done_m | spur;
   assign mm_result = mm_done_m ? mm_res_m : 16'hBEEF;

   always @(negedge clk) begin
      if (!resetn) begin
         pend      <= 1'b0;
         mm_done_m <= 1'b0;
         spur      <= 1'b0;
      end else begin
         mm_done_m <= 1'b0;
         spur      <= 1'b0;
         if (mm_start) begin
            start_cnt <= start_cnt + 1;
            if (pend) overlap_err <= overlap_err + 1;
            pend     <= 1'b1;
            a0       <= mm_a;
            b0       <= mm_b;
            m0       <= mm_m;
            res_pend <= mm_model(mm_a, mm_b, mm_m);
            lat_cnt  <= int'($urandom_range(40, 1));
         end else if (pend) begin
            if (mm_a !== a0 || mm_b !== b0 || mm_m !== m0) hold_err <= hold_err + 1;
            if (lat_cnt == 1) begin
               mm_done_m <= 1'b1;
               mm_res_m  <= res_pend;
               pend      <= 1'b0;
            end else begin
               lat_cnt <= lat_cnt - 1;
            end
         end else if (spur_en) begin
            spur <= 1'b1;
         end
      end
   end

   always @(negedge clk) if (resetn && done) done_cnt <= done_cnt + 1;

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic pulse_start(input logic [W-1:0] x, input logic [EB-1:0] e,
                              input logic [W-1:0] m);
      logic [31:0] r;
      logic [31:0] r2;
      r     = 32'h0001_0000 % {16'h0, m};
      r2    = (r * r) % {16'h0, m};
      in_x  = x;
      in_e  = e;
      in_m  = m;
      in_r  = r[W-1:0];
      in_r2 = r2[W-1:0];
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 4000; n++) begin
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   // Ends one cycle after done, i.e. a following start lands on the cycle after done.
   task automatic run_op(input logic [W-1:0] x, input logic [EB-1:0] e, input logic [W-1:0] m,
                         output logic [W-1:0] res, output int starts, output int dones,
                         output bit ok, output logic busy_after, output logic done_after);
      int s0;
      int d0;
      s0 = start_cnt;
      d0 = done_cnt;
      pulse_start(x, e, m);
      wait_done(ok);
      res = result;
      @(posedge clk); #1;
      busy_after = busy;
      done_after = done;
      starts     = start_cnt - s0;
      dones      = done_cnt - d0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vectors += 7;
      if (result !== 16'h0)  begin miscompares++; $display("FAIL reset_result got=%h want=0", result); end
      if (done !== 1'b0)     begin miscompares++; $display("FAIL reset_done got=%b want=0", done); end
      if (busy !== 1'b0)     begin miscompares++; $display("FAIL reset_busy got=%b want=0", busy); end
      if (mm_start !== 1'b0) begin miscompares++; $display("FAIL reset_mm_start got=%b want=0", mm_start); end
      if (mm_a !== 16'h0)    begin miscompares++; $display("FAIL reset_mm_a got=%h want=0", mm_a); end
      if (mm_b !== 16'h0)    begin miscompares++; $display("FAIL reset_mm_b got=%h want=0", mm_b); end
      if (mm_m !== 16'h0)    begin miscompares++; $display("FAIL reset_mm_m got=%h want=0", mm_m); end
      resetn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_vectors(input string tag);
      // x, e, m, x^e mod m, expected product count (8 + popcount(e) + 2)
      logic [W-1:0]  vx[6] = '{16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd3};
      logic [EB-1:0] ve[6] = '{8'h0D, 8'h00, 8'h01, 8'h80, 8'hFF, 8'h0D};
      logic [W-1:0]  vm[6] = '{16'd97, 16'd97, 16'd97, 16'd97, 16'd97, 16'd11};
      logic [W-1:0]  vr[6] = '{16'd29, 16'd1, 16'd5, 16'd35, 16'd51, 16'd5};
      int            vs[6] = '{13, 10, 11, 11, 18, 13};
      logic [W-1:0]  res;
      int            starts, dones;
      bit            ok;
      logic          ba, da;
      for (int i = 0; i < 6; i++) begin
         run_op(vx[i], ve[i], vm[i], res, starts, dones, ok, ba, da);
         vectors += 5;
         if (!ok) begin
            miscompares++;
            $display("FAIL %s_%0d_timeout done not seen within budget", tag, i);
         end
         if (res !== vr[i]) begin
            miscompares++;
            $display("FAIL %s_%0d_result got=%0d want=%0d", tag, i, res, vr[i]);
         end
         if (starts != vs[i]) begin
            miscompares++;
            $display("FAIL %s_%0d_mm_starts got=%0d want=%0d", tag, i, starts, vs[i]);
         end
         if (dones != 1) begin
            miscompares++;
            $display("FAIL %s_%0d_done_pulses got=%0d want=1", tag, i, dones);
         end
         if (ba !== 1'b0 || da !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_%0d_after_done busy=%b done=%b want 0/0", tag, i, ba, da);
         end
      end
   endtask

   task automatic test_mid_start;
      int s0, d0;
      bit ok;
      s0 = start_cnt;
      d0 = done_cnt;
      pulse_start(16'd5, 8'h0D, 16'd97);
      repeat (10) @(posedge clk);
      #1;
      pulse_start(16'd7, 8'h01, 16'd97);  // must be ignored while busy
      wait_done(ok);
      vectors += 3;
      if (!ok || result !== 16'd29) begin
         miscompares++;
         $display("FAIL mid_start_result got=%0d want=29 (done seen=%0b)", result, ok);
      end
      @(posedge clk); #1;
      if (start_cnt - s0 != 13) begin
         miscompares++;
         $display("FAIL mid_start_mm_starts got=%0d want=13", start_cnt - s0);
      end
      if (done_cnt - d0 != 1) begin
         miscompares++;
         $display("FAIL mid_start_done_pulses got=%0d want=1", done_cnt - d0);
      end
   endtask

   task automatic test_reset_mid;
      int s0, d0, n;
      logic [W-1:0] res;
      int starts, dones;
      bit ok;
      logic ba, da;
      s0 = start_cnt;
      pulse_start(16'd5, 8'h0D, 16'd97);
      // For e=0x0D the 7th product is the first multiply (bit 3).
      n = 0;
      while (start_cnt - s0 < 7 && n < 4000) begin
         @(posedge clk); #1;
         n++;
      end
      vectors++;
      if (start_cnt - s0 != 7) begin
         miscompares++;
         $display("FAIL reset_mid_reach_mul got=%0d products want=7", start_cnt - s0);
      end
      d0 = done_cnt;
      resetn = 1'b0;
      @(posedge clk); #1;
      vectors += 3;
      if (busy !== 1'b0)     begin miscompares++; $display("FAIL reset_mid_busy got=%b want=0", busy); end
      if (done !== 1'b0)     begin miscompares++; $display("FAIL reset_mid_done got=%b want=0", done); end
      if (mm_start !== 1'b0) begin miscompares++; $display("FAIL reset_mid_mm_start got=%b want=0", mm_start); end
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      vectors += 2;
      if (done_cnt != d0) begin
         miscompares++;
         $display("FAIL reset_mid_no_done got=%0d pulses want=0", done_cnt - d0);
      end
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_idle_busy got=%b want=0", busy);
      end
      run_op(16'd5, 8'h0D, 16'd97, res, starts, dones, ok, ba, da);
      vectors += 2;
      if (!ok || res !== 16'd29) begin
         miscompares++;
         $display("FAIL reset_mid_rerun_result got=%0d want=29 (done seen=%0b)", res, ok);
      end
      if (starts != 13) begin
         miscompares++;
         $display("FAIL reset_mid_rerun_mm_starts got=%0d want=13", starts);
      end
   endtask

   task automatic test_spurious;
      logic [W-1:0] res;
      int starts, dones;
      bit ok;
      logic ba, da;
      spur_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL spur_idle_busy got=%b want=0", busy);
      end
      run_op(16'd5, 8'h0D, 16'd97, res, starts, dones, ok, ba, da);
      vectors += 2;
      if (!ok || res !== 16'd29) begin
         miscompares++;
         $display("FAIL spur_e0d_result got=%0d want=29 (done seen=%0b)", res, ok);
      end
      if (starts != 13) begin
         miscompares++;
         $display("FAIL spur_e0d_mm_starts got=%0d want=13", starts);
      end
      run_op(16'd5, 8'h00, 16'd97, res, starts, dones, ok, ba, da);
      vectors += 2;
      if (!ok || res !== 16'd1) begin
         miscompares++;
         $display("FAIL spur_e00_result got=%0d want=1 (done seen=%0b)", res, ok);
      end
      if (dones != 1) begin
         miscompares++;
         $display("FAIL spur_e00_done_pulses got=%0d want=1", dones);
      end
      spur_en = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_handshake;
      vectors += 2;
      if (hold_err != 0) begin
         miscompares++;
         $display("FAIL handshake_operand_hold got=%0d changes want=0", hold_err);
      end
      if (overlap_err != 0) begin
         miscompares++;
         $display("FAIL handshake_overlap got=%0d early starts want=0", overlap_err);
      end
   endtask

   initial begin
      test_reset();
      test_vectors("basic");
      test_mid_start();
      test_reset_mid();
      test_spurious();
      test_vectors("back_to_back");
      test_handshake();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
